// File: rtl/key_scan_lut_if.sv
// Key-scanner bundle: raw switches and mode in, note enables/selection/strobes out.
// The bench drives through the master modport; key_scan_lut connects to the slave modport.
interface key_scan_lut_if #(
  parameter int N_KEYS = 8
);
  localparam int IDX_W = $clog2(N_KEYS);
  localparam int HC_W  = $clog2(N_KEYS + 1);

  logic [N_KEYS-1:0] sw;
  logic [1:0]        mode;
  logic [N_KEYS-1:0] en;
  logic [IDX_W-1:0]  note_idx;
  logic              note_valid;
  logic              note_on;
  logic              note_off;
  logic [HC_W-1:0]   held_count;

  modport master (
    output sw, mode,
    input  en, note_idx, note_valid, note_on, note_off, held_count
  );

  modport slave (
    input  sw, mode,
    output en, note_idx, note_valid, note_on, note_off, held_count
  );
endinterface

// File: rtl/key_scan_lut.sv
// Synchronises and debounces N_KEYS switches, then drives per-key enables plus a
// monophonic note selection (last/lowest/highest priority) with on/off strobes.
module key_scan_lut #(
  parameter int N_KEYS          = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int IDX_W           = $clog2(N_KEYS)
) (
  input logic           clk,
  input logic           rst,
  key_scan_lut_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HC_W  = $clog2(N_KEYS + 1);

  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  logic [N_KEYS-1:0] stable;
  logic [CNT_W-1:0]  cnt [N_KEYS];

  logic [N_KEYS-1:0] stable_d;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] fall;

  logic [IDX_W-1:0]  last_idx;
  logic              last_valid;
  logic [IDX_W-1:0]  last_idx_nxt;
  logic              last_valid_nxt;

  logic [IDX_W-1:0]  sel_idx;
  logic              sel_valid;
  logic [N_KEYS-1:0] en_nxt;

  logic [N_KEYS-1:0] en_q;
  logic [IDX_W-1:0]  note_idx_q;
  logic              note_valid_q;
  logic              note_on_q;
  logic              note_off_q;
  logic [HC_W-1:0]   held_count_q;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_KEYS-1:0] v);
    lowest_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  function automatic logic [IDX_W-1:0] highest_idx(input logic [N_KEYS-1:0] v);
    highest_idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i]) highest_idx = IDX_W'(i);
    end
  endfunction

  function automatic logic [HC_W-1:0] popcount(input logic [N_KEYS-1:0] v);
    popcount = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      popcount = popcount + HC_W'(v[i]);
    end
  endfunction

  // Stage 0/1: two-flop synchroniser and per-key debounce counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int k = 0; k < N_KEYS; k++) cnt[k] <= '0;
    end else begin
      s1 <= bus.sw;
      s2 <= s1;
      for (int k = 0; k < N_KEYS; k++) begin
        if (s2[k] == stable[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[k] <= ~stable[k];
          cnt[k]    <= '0;
        end else begin
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  // Last-note tracking runs in every mode so switching into mode 1 picks up a sane note.
  always_comb begin
    last_idx_nxt   = last_idx;
    last_valid_nxt = last_valid;
    if (|rise) begin
      last_idx_nxt   = lowest_idx(rise);
      last_valid_nxt = 1'b1;
    end else if (last_valid && fall[last_idx]) begin
      if (|stable) begin
        last_idx_nxt = lowest_idx(stable);
      end else begin
        last_valid_nxt = 1'b0;
      end
    end
  end

  always_comb begin
    sel_idx   = lowest_idx(stable);
    sel_valid = |stable;
    case (bus.mode)
      2'd1: begin
        sel_idx   = last_idx_nxt;
        sel_valid = last_valid_nxt;
      end
      2'd3: sel_idx = highest_idx(stable);
      default: ;
    endcase
  end

  always_comb begin
    en_nxt = '0;
    if (bus.mode == 2'd0) begin
      en_nxt = stable;
    end else if (sel_valid) begin
      en_nxt = N_KEYS'(1) << sel_idx;
    end
  end

  // Stage 2: registered edge detect, selection state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d     <= '0;
      last_idx     <= '0;
      last_valid   <= 1'b0;
      en_q         <= '0;
      note_idx_q   <= '0;
      note_valid_q <= 1'b0;
      note_on_q    <= 1'b0;
      note_off_q   <= 1'b0;
      held_count_q <= '0;
    end else begin
      stable_d     <= stable;
      last_idx     <= last_idx_nxt;
      last_valid   <= last_valid_nxt;
      en_q         <= en_nxt;
      note_idx_q   <= sel_idx;
      note_valid_q <= sel_valid;
      note_on_q    <= sel_valid && (!note_valid_q || (sel_idx != note_idx_q));
      note_off_q   <= !sel_valid && note_valid_q;
      held_count_q <= popcount(stable);
    end
  end

  assign bus.en         = en_q;
  assign bus.note_idx   = note_idx_q;
  assign bus.note_valid = note_valid_q;
  assign bus.note_on    = note_on_q;
  assign bus.note_off   = note_off_q;
  assign bus.held_count = held_count_q;

endmodule

// File: tb/tb_key_scan_lut.sv
// Directed bench for key_scan_lut with a short debounce window of 4 cycles.
module tb_key_scan_lut;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  key_scan_lut_if #(.N_KEYS(8)) bus ();

  key_scan_lut #(
    .N_KEYS          (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sw;
    logic [1:0] mode;
    logic [7:0] en;
    int         idx;
    logic       valid;
    int         held;
    int         n_on;
    int         n_off;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int on_cnt;
    int off_cnt;
    int both;
    on_cnt  = 0;
    off_cnt = 0;
    both    = 0;
    bus.sw   = v.sw;
    bus.mode = v.mode;
    repeat (12) begin
      tick();
      on_cnt  += int'(bus.note_on);
      off_cnt += int'(bus.note_off);
      if (bus.note_on && bus.note_off) both++;
    end
    chk($sformatf("v%0d_en", k), bus.en, v.en);
    chk($sformatf("v%0d_valid", k), bus.note_valid, v.valid);
    if (v.valid) chk($sformatf("v%0d_idx", k), bus.note_idx, v.idx);
    chk($sformatf("v%0d_held", k), bus.held_count, v.held);
    chk($sformatf("v%0d_on_count", k), on_cnt, v.n_on);
    chk($sformatf("v%0d_off_count", k), off_cnt, v.n_off);
    chk($sformatf("v%0d_on_off_both", k), both, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //           sw     mode  en     idx valid held on off
    vecs[0]  = '{8'h04, 2'd1, 8'h04, 2, 1'b1, 1, 1, 0};
    vecs[1]  = '{8'h24, 2'd1, 8'h20, 5, 1'b1, 2, 1, 0};
    vecs[2]  = '{8'h04, 2'd1, 8'h04, 2, 1'b1, 1, 1, 0};
    vecs[3]  = '{8'h00, 2'd1, 8'h00, 0, 1'b0, 0, 0, 1};
    vecs[4]  = '{8'h52, 2'd2, 8'h02, 1, 1'b1, 3, 1, 0};
    vecs[5]  = '{8'h52, 2'd3, 8'h40, 6, 1'b1, 3, 1, 0};
    vecs[6]  = '{8'h52, 2'd0, 8'h52, 1, 1'b1, 3, 1, 0};
    vecs[7]  = '{8'h00, 2'd0, 8'h00, 0, 1'b0, 0, 0, 1};
    vecs[8]  = '{8'h88, 2'd1, 8'h08, 3, 1'b1, 2, 1, 0};
    vecs[9]  = '{8'h88, 2'd0, 8'h88, 3, 1'b1, 2, 0, 0};
    vecs[10] = '{8'h00, 2'd0, 8'h00, 0, 1'b0, 0, 0, 1};
    vecs[11] = '{8'h04, 2'd1, 8'h04, 2, 1'b1, 1, 1, 0};
    vecs[12] = '{8'h02, 2'd1, 8'h02, 1, 1'b1, 1, 1, 0};
    vecs[13] = '{8'h00, 2'd1, 8'h00, 0, 1'b0, 0, 0, 1};

    // Reset held with all switches pressed: outputs stay zero.
    rst      = 1'b1;
    bus.sw   = 8'hFF;
    bus.mode = 2'd0;
    repeat (4) begin
      tick();
      chk("rst_en", bus.en, 8'h00);
      chk("rst_valid_on_off", {bus.note_valid, bus.note_on, bus.note_off}, 3'b000);
      chk("rst_held", bus.held_count, 0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) begin
        chk($sformatf("rel_en_e%0d", e), bus.en, 8'h00);
      end else begin
        chk("rel_en_e7", bus.en, 8'hFF);
        chk("rel_held_e7", bus.held_count, 8);
        chk("rel_on_e7", bus.note_on, 1'b1);
        chk("rel_idx_e7", bus.note_idx, 0);
      end
    end
    bus.sw = 8'h00;
    repeat (12) tick();

    // 3-cycle glitch on key 3 must be rejected.
    begin
      int seen;
      seen = 0;
      bus.sw = 8'h08;
      repeat (3) tick();
      bus.sw = 8'h00;
      repeat (15) begin
        tick();
        if (bus.en != 8'h00 || bus.note_on || bus.note_off) seen++;
      end
      chk("glitch3_activity", seen, 0);
    end

    // 4-cycle pulse on key 3 is accepted at edge 7.
    bus.sw = 8'h08;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 4) bus.sw = 8'h00;
      if (e == 6) chk("pulse4_en_e6", bus.en, 8'h00);
      if (e == 7) begin
        chk("pulse4_en_e7", bus.en, 8'h08);
        chk("pulse4_on_e7", bus.note_on, 1'b1);
        chk("pulse4_idx_e7", bus.note_idx, 3);
      end
      if (e == 8) chk("pulse4_on_e8", bus.note_on, 1'b0);
    end
    repeat (15) tick();
    chk("pulse4_released", bus.en, 8'h00);

    for (int k = 0; k < 14; k++) run_vec(vecs[k], k);

    // Mode 2 -> 3 switch gives note_on one cycle later.
    bus.sw   = 8'h52;
    bus.mode = 2'd2;
    repeat (12) tick();
    chk("m2_idx", bus.note_idx, 1);
    bus.mode = 2'd3;
    tick();
    chk("m3_on", bus.note_on, 1'b1);
    chk("m3_idx", bus.note_idx, 6);
    chk("m3_en_onehot", bus.en, 8'h40);
    tick();
    chk("m3_on_clear", bus.note_on, 1'b0);
    bus.sw = 8'h00;
    repeat (12) tick();

    // Async reset mid-note and mid-count, then full latency after release.
    bus.mode = 2'd1;
    bus.sw   = 8'h10;
    repeat (12) tick();
    chk("pre_arst_en", bus.en, 8'h10);
    bus.sw = 8'h11;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_en", bus.en, 8'h00);
    chk("arst_valid", bus.note_valid, 1'b0);
    chk("arst_held", bus.held_count, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) begin
        chk($sformatf("arst_rel_en_e%0d", e), bus.en, 8'h00);
      end else begin
        chk("arst_rel_en_e7", bus.en, 8'h01);
        chk("arst_rel_idx_e7", bus.note_idx, 0);
        chk("arst_rel_held_e7", bus.held_count, 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_scan_lut.md
# key_scan_lut

Parametrised successor to the piano switch-to-note LUT. It synchronises and debounces `N_KEYS` raw switch inputs and produces per-key note enables. It also produces a single selected-note index with valid, note-on and note-off strobes for a monophonic tone generator. It sits between the board switches and the tone-generation blocks.

## Interface
- `N_KEYS`, 8: number of key inputs (2..32); bit 0 = C, ascending.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required before a key change is accepted (≥1).
- `IDX_W`, `$clog2(N_KEYS)`: width of note index (derived; do not override).
- `clk` input 1: system clock. One clock; all logic on its rising edge.
- `rst` input 1: reset. Asynchronous, active-high.
- `sw` input `N_KEYS`: raw asynchronous switch levels, 1 = pressed.
- `mode` input 2: 0 = polyphonic, 1 = mono last-note priority, 2 = mono lowest-note priority, 3 = mono highest-note priority.
- `en` output `N_KEYS`: registered per-key note enables.
- `note_idx` output `IDX_W`: selected note index.
- `note_valid` output 1: `note_idx` is meaningful.
- `note_on` output 1: one-cycle strobe when a new note is selected.
- `note_off` output 1: one-cycle strobe when selection goes from valid to invalid.
- `held_count` output `$clog2(N_KEYS+1)`: number of debounced keys held.

## Operation
- Synchroniser: two flops per key, `s1`→`s2`. Reset value 0.
- Debounce, per key: `stable` bit and counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Any edge where `s2 == stable` clears the counter.
  - Otherwise the counter increments. On the edge where it would reach `DEBOUNCE_CYCLES`, `stable` toggles and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`.
- `rise[k]` = stable 0→1 this edge; `fall[k]` = 1→0 (internal, registered compare against previous `stable`).
- `held_count` = popcount(`stable`), registered.
- `en`:
  - Mode 0: `en` = `stable`.
  - Modes 1-3: `en` is one-hot at `note_idx` when `note_valid`, else all zero.
- Selection. Registers `last_idx` and `last_valid` are updated in all modes so that a mode switch is seamless:
  - On any `rise`: `last_idx` = lowest-index rising key; `last_valid` = 1.
  - When the key at `last_idx` falls without a simultaneous rise: fall back to lowest-index held key. If none is held, `last_valid` = 0.
  - Mode 1 selection = `last_idx`/`last_valid`.
  - Mode 2 selection = lowest set bit of `stable`.
  - Mode 3 selection = highest set bit of `stable`.
  - Mode 0 selection = lowest set bit of `stable` (`note_idx`/`note_valid` still driven).
- Strobes:
  - `note_on` = 1 when the new selection is valid and either the previous one was invalid or the index changed.
  - `note_off` = 1 when valid→invalid.
  - `note_on` and `note_off` are never both 1.
- `mode` is sampled each cycle. A change takes effect on the next output update and may itself cause a `note_on`.

## Timing
- Reset (async assert, sync-safe deassert assumed upstream): all synchroniser flops, `stable`, counters, `last_idx`, `last_valid`, `en`, `note_idx`, `note_valid`, `note_on`, `note_off` and `held_count` = 0.
- Latency: a clean `sw` change set up before edge 1 reaches `s2` at edge 2. `stable` toggles at edge 2+`DEBOUNCE_CYCLES`. Outputs (`en`, selection, strobes, `held_count`) update at edge 3+`DEBOUNCE_CYCLES`.
- Simultaneous rises on several keys in the same cycle: lowest index wins for `last_idx`.
- Simultaneous rise and fall in the same cycle: the rise wins; `last_idx` takes the rising key.
- Counter width must hold `DEBOUNCE_CYCLES` without wrap. With `DEBOUNCE_CYCLES` = 1, a change is accepted after one disagreeing cycle.
- Reset mid-debounce discards the partial count. After release, a held switch needs the full latency again to appear.

## Test plan
- Reset: hold `rst`, drive `sw` = 8'hFF -> all outputs 0 throughout. Release with `DEBOUNCE_CYCLES` = 4 -> `en` = 8'hFF exactly 7 edges after release, `held_count` = 8.
- Glitch rejection (`DEBOUNCE_CYCLES` = 4): pulse `sw[3]` high for 3 cycles -> `en` stays 0, no strobes. A 4-cycle pulse -> `en[3]` = 1 at edge 7 and `note_on` single-cycle with `note_idx` = 3.
- Mode 1: press key 2, then key 5, then release 5 -> `note_idx` 2→5→2, three `note_on` pulses. Release 2 -> `note_valid` = 0 and one `note_off`.
- Modes 2/3 with keys 1, 4, 6 held -> `note_idx` = 1 in mode 2 and 6 in mode 3. Switching `mode` 2→3 gives `note_on` with idx 6 one cycle later. `en` is one-hot.
- Simultaneous press of keys 3 and 7 in mode 1 -> `note_idx` = 3. Mode 0 with the same keys -> `en` = 8'h88, `held_count` = 2.
- Async reset asserted mid-count and mid-note -> outputs 0 immediately (no clock edge). Key re-accepted only after full latency following release.
